// File: rtl/obstacle_pkg.sv
// Shared obstacle definitions: widths, obstacle types, speed thresholds and
// spawner scheduling constants/helpers.
package obstacle_pkg;

    localparam int unsigned SPEED_W       = 15;
    localparam int unsigned RNG_W         = 11;
    localparam int unsigned XPOS_W        = 11;
    localparam int unsigned WIDTH_W       = 10;
    localparam int unsigned GAP_W         = 11;
    localparam int unsigned SUM_W         = 13;
    localparam int unsigned SPEED_SCALE   = 1000;
    localparam int unsigned GAME_WIDTH    = 640;

    localparam int unsigned MAX_DUP       = 2;
    localparam int unsigned CLEAR_UPDATES = 180;
    localparam int unsigned DUP_W         = $clog2(MAX_DUP + 1);
    localparam int unsigned CLEAR_W       = $clog2(CLEAR_UPDATES + 1);

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        CACTUS_SMALL = 2'd1,
        CACTUS_LARGE = 2'd2,
        PTERODACTYL  = 2'd3
    } type_t;

    // Minimum horizon speed (SPEED_SCALE fixed point) at which a type may appear.
    localparam logic [SPEED_W-1:0] MIN_SPEED [4] = '{15'd0, 15'd0, 15'd0, 15'd8500};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLEARING = 2'd1,
        SPAWNING = 2'd2,
        CRASHED  = 2'd3
    } spawner_state_t;

    // Cyclic successor used to break a run of identical types.
    function automatic type_t next_type(input type_t t);
        case (t)
            CACTUS_SMALL: return CACTUS_LARGE;
            CACTUS_LARGE: return PTERODACTYL;
            default:      return CACTUS_SMALL;
        endcase
    endfunction

    // Demote a type to the small cactus when the horizon is too slow for it.
    function automatic type_t speed_gate(input type_t t, input logic [SPEED_W-1:0] speed);
        if (speed < MIN_SPEED[t]) begin
            return CACTUS_SMALL;
        end
        return t;
    endfunction

endpackage

// File: rtl/obstacle_type_picker.sv
// Combinational obstacle type selection.
//   rng_bits  : low random bits, mapped onto the three spawnable types
//   speed     : horizon speed for the per-type speed gate
//   last_type : type of the previous spawn
//   dup_cnt   : length of the current run of last_type
//   cand_c    : chosen type for the next spawn
module obstacle_type_picker
    import obstacle_pkg::*;
(
    input  logic [1:0]         rng_bits,
    input  logic [SPEED_W-1:0] speed,
    input  type_t              last_type,
    input  logic [DUP_W-1:0]   dup_cnt,
    output type_t              cand_c
);

    logic [1:0] rng_mod;
    type_t      base;
    type_t      gated;

    // Random pick, speed gate, then break an over-long run of one type.
    always_comb begin
        rng_mod = rng_bits % 2'd3;
        base    = type_t'(2'(rng_mod + 2'd1));
        gated   = speed_gate(base, speed);
        cand_c  = gated;
        if ((gated == last_type) && (dup_cnt == DUP_W'(MAX_DUP))) begin
            cand_c = speed_gate(next_type(gated), speed);
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// Horizon-level obstacle scheduler: decides on each game update whether a new
// obstacle enters, picks the free slot and type, and drives start/typ.
//   clk, rst    : clock, asynchronous active-high reset
//   update      : one-cycle frame tick; all state advances only on it
//   game_start  : game running level
//   crash       : freezes spawning for good (until rst)
//   speed       : horizon speed
//   rng_data    : free-running random word
//   slot_active : per-slot RUNNING flags
//   slot_x_pos  : per-slot signed x position
//   slot_width  : per-slot width
//   slot_gap    : per-slot gap to the next obstacle
//   start       : per-slot start pulse (one update interval), registered
//   typ         : per-slot obstacle type, registered and held
module obstacle_spawner
    import obstacle_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 3
)
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               update,
    input  logic                               game_start,
    input  logic                               crash,
    input  logic [SPEED_W-1:0]                 speed,
    input  logic [RNG_W-1:0]                   rng_data,
    input  logic [NUM_SLOTS-1:0]               slot_active,
    input  logic [NUM_SLOTS-1:0][XPOS_W-1:0]   slot_x_pos,
    input  logic [NUM_SLOTS-1:0][WIDTH_W-1:0]  slot_width,
    input  logic [NUM_SLOTS-1:0][GAP_W-1:0]    slot_gap,
    output logic [NUM_SLOTS-1:0]               start,
    output type_t                              typ [NUM_SLOTS]
);

    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    spawner_state_t       state, state_next;
    logic [CLEAR_W-1:0]   clear_cnt, clear_cnt_next;
    logic [SLOT_W-1:0]    last_slot, last_slot_next;
    type_t                last_type, last_type_next;
    logic [DUP_W-1:0]     dup_cnt, dup_cnt_next;
    logic                 pending, pending_next;
    logic [NUM_SLOTS-1:0] start_next;
    type_t                typ_next [NUM_SLOTS];

    logic                 free_found_c;
    logic [SLOT_W-1:0]    free_slot_c;
    logic [XPOS_W-1:0]    sel_x;
    logic [WIDTH_W-1:0]   sel_w;
    logic [GAP_W-1:0]     sel_g;
    logic signed [SUM_W-1:0] gap_sum_c;
    logic                 gap_ok_c;
    logic                 spawn_c;
    type_t                cand_c;
    logic                 unused_rng;

    assign unused_rng = ^rng_data[RNG_W-1:2];

    obstacle_type_picker u_picker (
        .rng_bits  (rng_data[1:0]),
        .speed     (speed),
        .last_type (last_type),
        .dup_cnt   (dup_cnt),
        .cand_c    (cand_c)
    );

    // Lowest-index free slot.
    always_comb begin
        free_found_c = 1'b0;
        free_slot_c  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_found_c = 1'b1;
                free_slot_c  = SLOT_W'(i);
            end
        end
    end

    // Trailing edge of the last spawned obstacle plus its gap; x_pos is signed,
    // so an obstacle partly off the left edge yields a negative sum.
    always_comb begin
        sel_x     = slot_x_pos[last_slot];
        sel_w     = slot_width[last_slot];
        sel_g     = slot_gap[last_slot];
        gap_sum_c = {{(SUM_W - XPOS_W){sel_x[XPOS_W-1]}}, sel_x}
                  + {{(SUM_W - WIDTH_W){1'b0}}, sel_w}
                  + {{(SUM_W - GAP_W){1'b0}}, sel_g};
        gap_ok_c  = gap_sum_c < $signed(SUM_W'(GAME_WIDTH));
    end

    // Next-state and spawn decision.
    always_comb begin
        state_next     = state;
        clear_cnt_next = clear_cnt;
        last_slot_next = last_slot;
        last_type_next = last_type;
        dup_cnt_next   = dup_cnt;
        pending_next   = 1'b0;
        start_next     = '0;
        typ_next       = typ;
        spawn_c        = 1'b0;

        case (state)
            IDLE: begin
                if (game_start) begin
                    state_next     = CLEARING;
                    clear_cnt_next = '0;
                end
            end
            CLEARING: begin
                clear_cnt_next = CLEAR_W'(clear_cnt + 1'b1);
                if (clear_cnt == CLEAR_W'(CLEAR_UPDATES - 1)) begin
                    state_next = SPAWNING;
                end
            end
            SPAWNING: begin
                spawn_c = !pending && free_found_c && (!(|slot_active) || gap_ok_c);
            end
            CRASHED: begin
                state_next = CRASHED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Crash overrides everything, including a spawn due this update.
        if (crash) begin
            state_next = CRASHED;
            spawn_c    = 1'b0;
        end

        if (spawn_c) begin
            start_next[free_slot_c] = 1'b1;
            typ_next[free_slot_c]   = cand_c;
            pending_next            = 1'b1;
            last_slot_next          = free_slot_c;
            last_type_next          = cand_c;
            dup_cnt_next            = (cand_c == last_type) ? DUP_W'(dup_cnt + 1'b1) : DUP_W'(1);
        end
    end

    // State registers, advanced only on update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clear_cnt <= '0;
            last_slot <= '0;
            last_type <= NONE;
            dup_cnt   <= '0;
            pending   <= 1'b0;
            start     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                typ[i] <= NONE;
            end
        end else if (update) begin
            state     <= state_next;
            clear_cnt <= clear_cnt_next;
            last_slot <= last_slot_next;
            last_type <= last_type_next;
            dup_cnt   <= dup_cnt_next;
            pending   <= pending_next;
            start     <= start_next;
            typ       <= typ_next;
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner: expected start/typ per update are
// queued as stimulus is applied and compared after the update lands.
module tb_obstacle_spawner;
    import obstacle_pkg::*;

    localparam int unsigned N = 3;

    logic                        clk;
    logic                        rst;
    logic                        update;
    logic                        game_start;
    logic                        crash;
    logic [SPEED_W-1:0]          speed;
    logic [RNG_W-1:0]            rng_data;
    logic [N-1:0]                slot_active;
    logic [N-1:0][XPOS_W-1:0]    slot_x_pos;
    logic [N-1:0][WIDTH_W-1:0]   slot_width;
    logic [N-1:0][GAP_W-1:0]     slot_gap;
    logic [N-1:0]                start;
    type_t                       typ [N];

    typedef struct {
        string        tag;
        logic [N-1:0] start;
        type_t        typ;
    } exp_t;

    exp_t  sb_q[$];
    int    checks;
    int    errors;
    type_t dup_exp [6];

    obstacle_spawner #(.NUM_SLOTS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .update      (update),
        .game_start  (game_start),
        .crash       (crash),
        .speed       (speed),
        .rng_data    (rng_data),
        .slot_active (slot_active),
        .slot_x_pos  (slot_x_pos),
        .slot_width  (slot_width),
        .slot_gap    (slot_gap),
        .start       (start),
        .typ         (typ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_update();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    // Queue the expectation, apply one update, then pop and compare.
    task automatic step(input string tag, input logic [N-1:0] exp_start, input type_t exp_typ);
        exp_t e;
        e.tag   = tag;
        e.start = exp_start;
        e.typ   = exp_typ;
        sb_q.push_back(e);
        do_update();
        e = sb_q.pop_front();
        check({e.tag, "_start"}, 32'(start), 32'(e.start));
        for (int i = 0; i < N; i++) begin
            if (e.start[i]) check({e.tag, "_typ"}, 32'(typ[i]), 32'(e.typ));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset, raise game_start, then run the whole no-spawn clearing window:
    // the game_start update plus CLEAR_UPDATES updates with no start.
    task automatic start_game();
        apply_reset();
        game_start = 1'b1;
        step("enter_clear", '0, NONE);
        for (int k = 1; k <= int'(CLEAR_UPDATES); k++) step("clearing", '0, NONE);
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b0;
        update      = 1'b0;
        game_start  = 1'b0;
        crash       = 1'b0;
        speed       = 15'd9000;
        rng_data    = '0;
        slot_active = '0;
        slot_x_pos  = '0;
        slot_width  = '0;
        slot_gap    = '0;
        checks      = 0;
        errors      = 0;
        dup_exp     = '{CACTUS_SMALL, CACTUS_SMALL, CACTUS_LARGE,
                        CACTUS_SMALL, CACTUS_SMALL, CACTUS_LARGE};

        // Reset state
        apply_reset();
        check("rst_start", 32'(start), 32'(0));
        for (int i = 0; i < N; i++) check("rst_typ", 32'(typ[i]), 32'(NONE));

        // Clearing window, then first spawn on the following update to slot 0;
        // with rng forcing SMALL the run limit inserts a LARGE every third spawn.
        start_game();
        for (int i = 0; i < 6; i++) begin
            step("dup", 3'b001, dup_exp[i]);
            step("pending", '0, NONE);
        end

        // Speed gate on the pterodactyl (last type LARGE here).
        rng_data = 11'd2;
        speed    = 15'd8000;
        step("gate_lo", 3'b001, CACTUS_SMALL);
        step("pending", '0, NONE);
        speed    = 15'd9000;
        step("gate_hi", 3'b001, PTERODACTYL);
        step("pending", '0, NONE);

        // Spacing against the last spawned slot.
        rng_data      = 11'd0;
        slot_active   = 3'b001;
        slot_x_pos[0] = 11'd400;
        slot_width[0] = 10'd17;
        slot_gap[0]   = 11'd120;
        step("space_537", 3'b010, CACTUS_SMALL);
        step("pending", '0, NONE);
        slot_active   = 3'b011;
        slot_x_pos[1] = 11'd520;
        slot_width[1] = 10'd17;
        slot_gap[1]   = 11'd120;
        for (int k = 0; k < 3; k++) step("space_657", '0, NONE);
        slot_x_pos[1] = 11'd503;
        step("space_640", '0, NONE);
        slot_x_pos[1] = 11'd502;
        step("space_639", 3'b100, CACTUS_SMALL);
        step("pending", '0, NONE);
        slot_active   = 3'b101;
        slot_x_pos[2] = 11'(-700);
        slot_width[2] = 10'd17;
        slot_gap[2]   = 11'd120;
        step("space_neg", 3'b010, CACTUS_LARGE);
        step("pending", '0, NONE);
        check("typ_held0", 32'(typ[0]), 32'(PTERODACTYL));

        // All slots busy: no spawn.
        slot_active = 3'b111;
        for (int k = 0; k < 3; k++) step("full", '0, NONE);

        // Crash with a spawn due, then sticky.
        slot_active = 3'b000;
        crash       = 1'b1;
        step("crash", '0, NONE);
        crash       = 1'b0;
        for (int k = 0; k < 3; k++) step("crashed", '0, NONE);
        check("crash_typ1", 32'(typ[1]), 32'(CACTUS_LARGE));

        // Asynchronous reset while start is high.
        start_game();
        step("restart", 3'b001, CACTUS_SMALL);
        #1 rst = 1'b1;
        #1;
        check("async_rst_start", 32'(start), 32'(0));
        check("async_rst_typ", 32'(typ[0]), 32'(NONE));
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
